sine_nco: RTL and testbench

// - Multi-channel numerically controlled sine generator; successor to the single-channel table walker.
// - Phase accumulator with runtime frequency tuning word, per-channel phase offset, quarter-wave LUT.
// - Outputs signed two's-complement samples over a valid/ready stream to downstream DSP/DAC blocks.
//

---
 rtl/sine_nco.sv | 157 +++++++++++++++
 tb/tb_sine_nco.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sine_nco.sv
// sine_nco: multi-channel quarter-wave sine NCO with a 2-stage pipeline and valid/ready output.
// Optional feature macro: SINE_NCO_COS_EN adds a quadrature cosine output.
module sine_nco #(
  parameter int SINE_W     = 8,
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 5,
  parameter int NUM_CH     = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [PHASE_W-1:0]        ftw,
  input  logic [NUM_CH*PHASE_W-1:0] phase_off,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*SINE_W-1:0]  sine
`ifdef SINE_NCO_COS_EN
  ,
  output logic [NUM_CH*SINE_W-1:0]  cosine
`endif
);

  localparam int LUT_N = 2 ** LUT_ADDR_W;
  localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(1'b1) << (PHASE_W - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Half-sample offset keeps the mirrored quadrants symmetric without a duplicated endpoint.
  function automatic logic [SINE_W-1:0] lut_entry(input int k);
    real amp;
    real ang;
    amp = real'((2 ** (SINE_W - 1)) - 1);
    ang = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_N);
    return SINE_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  function automatic logic [LUT_ADDR_W-1:0] fold_addr(input logic [PHASE_W-1:0] p);
    logic [LUT_ADDR_W-1:0] a;
    a = p[PHASE_W-3 -: LUT_ADDR_W];
    return p[PHASE_W-2] ? ~a : a;
  endfunction

  function automatic logic [SINE_W-1:0] apply_sign(input logic [SINE_W-1:0] mag, input logic neg);
    return neg ? (~mag + SINE_W'(1'b1)) : mag;
  endfunction

  logic [SINE_W-1:0]  lut_s [LUT_N];
  state_t             state_r;
  logic [PHASE_W-1:0] acc_r;
  logic [PHASE_W-1:0] ftw_q_r;
  logic               s1_valid_r;
  logic [SINE_W-1:0]  s1_mag_r [NUM_CH];
  logic [NUM_CH-1:0]  s1_neg_r;
  logic [SINE_W-1:0]  sin_mag_s [NUM_CH];
  logic [NUM_CH-1:0]  sin_neg_s;
  logic               stall_s;
  logic               advance_s;
`ifdef SINE_NCO_COS_EN
  logic [SINE_W-1:0]  c1_mag_r [NUM_CH];
  logic [NUM_CH-1:0]  c1_neg_r;
  logic [SINE_W-1:0]  cos_mag_s [NUM_CH];
  logic [NUM_CH-1:0]  cos_neg_s;
`endif

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut_s[k] = lut_entry(k);
  end

  assign stall_s   = out_valid && !out_ready;
  assign advance_s = (state_r == RUN) && !stall_s;

  // Per-channel phase, quadrant fold and LUT read for the sample being issued.
  always_comb begin : phase_lookup
    logic [PHASE_W-1:0] p_v;
    p_v       = {PHASE_W{1'b0}};
    sin_neg_s = {NUM_CH{1'b0}};
`ifdef SINE_NCO_COS_EN
    cos_neg_s = {NUM_CH{1'b0}};
`endif
    for (int ch = 0; ch < NUM_CH; ch++) begin
      p_v           = acc_r + phase_off[ch*PHASE_W +: PHASE_W];
      sin_mag_s[ch] = lut_s[fold_addr(p_v)];
      sin_neg_s[ch] = p_v[PHASE_W-1];
`ifdef SINE_NCO_COS_EN
      p_v           = p_v + QUARTER;
      cos_mag_s[ch] = lut_s[fold_addr(p_v)];
      cos_neg_s[ch] = p_v[PHASE_W-1];
`endif
    end
  end

  // Run/drain state machine; DRAIN lets already-issued words leave before going idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    if (enable) state_r <= RUN;
        RUN:     if (!enable) state_r <= DRAIN;
        DRAIN: begin
          if (enable) state_r <= RUN;
          else if (!s1_valid_r && !out_valid) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Accumulator and both pipeline stages; load restarts and drops in-flight words, stall freezes all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r      <= {PHASE_W{1'b0}};
      ftw_q_r    <= {PHASE_W{1'b0}};
      s1_valid_r <= 1'b0;
      s1_neg_r   <= {NUM_CH{1'b0}};
      out_valid  <= 1'b0;
      sine       <= {(NUM_CH*SINE_W){1'b0}};
      for (int ch = 0; ch < NUM_CH; ch++) s1_mag_r[ch] <= {SINE_W{1'b0}};
`ifdef SINE_NCO_COS_EN
      c1_neg_r   <= {NUM_CH{1'b0}};
      cosine     <= {(NUM_CH*SINE_W){1'b0}};
      for (int ch = 0; ch < NUM_CH; ch++) c1_mag_r[ch] <= {SINE_W{1'b0}};
`endif
    end else if (load) begin
      acc_r      <= {PHASE_W{1'b0}};
      ftw_q_r    <= ftw;
      s1_valid_r <= 1'b0;
      out_valid  <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= advance_s;
      out_valid  <= s1_valid_r;
      if (advance_s) begin
        acc_r    <= acc_r + ftw_q_r;
        s1_neg_r <= sin_neg_s;
        for (int ch = 0; ch < NUM_CH; ch++) s1_mag_r[ch] <= sin_mag_s[ch];
`ifdef SINE_NCO_COS_EN
        c1_neg_r <= cos_neg_s;
        for (int ch = 0; ch < NUM_CH; ch++) c1_mag_r[ch] <= cos_mag_s[ch];
`endif
      end
      if (s1_valid_r) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          sine[ch*SINE_W +: SINE_W] <= apply_sign(s1_mag_r[ch], s1_neg_r[ch]);
`ifdef SINE_NCO_COS_EN
          cosine[ch*SINE_W +: SINE_W] <= apply_sign(c1_mag_r[ch], c1_neg_r[ch]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_nco.sv
// Directed, table-driven bench for sine_nco with default parameters (8-bit samples, 2 channels).
module tb_sine_nco;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        load;
  logic [15:0] ftw;
  logic [31:0] phase_off;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sine;
`ifdef SINE_NCO_COS_EN
  logic [15:0] cosine;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, idx, cnt;

  // round(127*sin(pi/2*(k+0.5)/32)), computed by hand
  int lut [32] = '{3, 9, 16, 22, 28, 34, 40, 46, 51, 57, 63, 68, 73, 78, 83, 88,
                   92, 96, 100, 104, 107, 111, 113, 116, 118, 121, 122, 124, 125, 126, 127, 127};

  typedef struct {
    logic [15:0] off0;
    logic [15:0] off1;
    int          exp0;
    int          exp1;
  } vec_t;
  vec_t vecs [5];

  always #5 clock = ~clock;

  sine_nco dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .load      (load),
    .ftw       (ftw),
    .phase_off (phase_off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sine      (sine)
`ifdef SINE_NCO_COS_EN
    ,
    .cosine    (cosine)
`endif
  );

  function automatic int model(input logic [15:0] p);
    int a;
    int m;
    a = int'(p[13:9]);
    m = p[14] ? lut[31 - a] : lut[a];
    return p[15] ? -m : m;
  endfunction

  function automatic int ch_sine(input int ch);
    logic signed [7:0] v;
    v = sine[ch*8 +: 8];
    return int'(v);
  endfunction

`ifdef SINE_NCO_COS_EN
  function automatic int ch_cos(input int ch);
    logic signed [7:0] v;
    v = cosine[ch*8 +: 8];
    return int'(v);
  endfunction
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_load(input logic [15:0] f);
    ftw  = f;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!out_valid && cycles < limit);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 3, 3};
    vecs[1] = '{16'h0000, 16'h4000, 3, 127};
    vecs[2] = '{16'h8000, 16'hC000, -3, -127};
    vecs[3] = '{16'h2000, 16'h0200, 92, 9};
    vecs[4] = '{16'h7E00, 16'hFE00, 3, -3};

    reset_n   = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    out_ready = 1'b1;
    ftw       = 16'h0200;
    phase_off = 32'h0;
    repeat (2) @(negedge clock);
    check("reset_valid", int'(out_valid), 0);
    check("reset_sine", int'(sine), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_no_valid", int'(out_valid), 0);

    // first word per offset pair, with issue-to-valid latency
    for (int i = 0; i < 5; i++) begin
      phase_off = {vecs[i].off1, vecs[i].off0};
      pulse_load(16'h0200);
      enable = 1'b1;
      wait_valid(20, cyc);
      check("vec_latency", cyc, 3);
      check("vec_ch0", ch_sine(0), vecs[i].exp0);
      check("vec_ch1", ch_sine(1), vecs[i].exp1);
`ifdef SINE_NCO_COS_EN
      check("vec_cos0", ch_cos(0), model(vecs[i].off0 + 16'h4000));
`endif
      enable = 1'b0;
      repeat (8) @(negedge clock);
    end

    // long stream with a 5-cycle backpressure window
    phase_off = {16'h4000, 16'h0000};
    pulse_load(16'h0200);
    enable = 1'b1;
    idx = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      out_ready = !(c >= 60 && c < 65);
      if (c >= 2) check("stream_valid", int'(out_valid), 1);
      if (out_valid) begin
        check("stream_ch0", ch_sine(0), model(16'(idx * 512)));
        check("stream_ch1", ch_sine(1), model(16'(idx * 512 + 16'h4000)));
`ifdef SINE_NCO_COS_EN
        check("stream_cos0", ch_cos(0), model(16'(idx * 512 + 16'h4000)));
`endif
        if (out_ready) idx++;
      end
    end
    check("stream_count", idx, 193);

    // load mid-run drops in-flight words and restarts at the new offset
    out_ready = 1'b1;
    phase_off[15:0] = 16'h8000;
    pulse_load(16'h0200);
    check("load_clears_valid", int'(out_valid), 0);
    wait_valid(20, cyc);
    check("load_latency", cyc, 2);
    check("load_ch0", ch_sine(0), -3);
    check("load_ch1", ch_sine(1), 127);

    // drop enable: buffered words drain, then output stays idle
    enable = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (out_valid) begin
        cnt++;
        check("drain_ch0", ch_sine(0), model(16'(16'h8000 + cnt * 512)));
      end
    end
    check("drain_words_le2", int'(cnt >= 1 && cnt <= 2), 1);
    check("drain_idle", int'(out_valid), 0);

    // async reset in the middle of a stream
    phase_off = {16'h4000, 16'h0000};
    enable = 1'b1;
    wait_valid(20, cyc);
    check("restart_latency", cyc, 3);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_valid", int'(out_valid), 0);
    check("midreset_sine", int'(sine), 0);
    enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("post_reset_idle", int'(out_valid), 0);
    end

    // ftw_q is zero after reset: constant stream at the offset phase
    enable = 1'b1;
    wait_valid(20, cyc);
    check("zero_ftw_latency", cyc, 3);
    for (int c = 0; c < 4; c++) begin
      check("zero_ftw_ch0", ch_sine(0), 3);
      check("zero_ftw_ch1", ch_sine(1), 127);
`ifdef SINE_NCO_COS_EN
      check("zero_ftw_cos1", ch_cos(1), -3);
`endif
      @(negedge clock);
    end
    enable = 1'b0;
    repeat (6) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
